// File: rtl/axi_pkg.sv
// AXI4-Lite response codes shared by the peripheral-bus slaves.
package axi_pkg;
    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
endpackage

// File: rtl/soc_addr_rules_pkg.sv
// Peripheral AXI-Lite crossbar address map: UART and timer each own a 4 KiB window.
package soc_addr_rules_pkg;
    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_rule_t;

    localparam int unsigned PERIPH_NUM_SLAVES = 2;

    localparam addr_rule_t AXIL_UART_ADDR_RULE  = '{idx: 32'd0, start_addr: 32'h1000_0000, end_addr: 32'h1000_1000};
    localparam addr_rule_t AXIL_TIMER_ADDR_RULE = '{idx: 32'd1, start_addr: 32'h1000_1000, end_addr: 32'h1000_2000};
endpackage

// File: rtl/soc_timer_pkg.sv
// Register map, control fields and helpers for the AXI-Lite timer.
package soc_timer_pkg;
    localparam int unsigned PRESCALE_WIDTH = 16;

    localparam logic [4:0] TIMER_CTRL_OFF     = 5'h00;
    localparam logic [4:0] TIMER_PRESCALE_OFF = 5'h04;
    localparam logic [4:0] TIMER_COUNT_OFF    = 5'h08;
    localparam logic [4:0] TIMER_COMPARE_OFF  = 5'h0C;
    localparam logic [4:0] TIMER_STATUS_OFF   = 5'h10;

    localparam int unsigned CTRL_EN_BIT          = 0;
    localparam int unsigned CTRL_AUTO_RELOAD_BIT = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT      = 2;

    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } ctrl_t;

    // Merge write data into an existing 32-bit value under byte strobes.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return res;
    endfunction
endpackage

// File: rtl/axil_timer_if.sv
// AXI4-Lite slave channel bundle for the timer peripheral.
interface axil_timer_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_timer_core.sv
// Prescaler, 32-bit up-counter and compare logic; emits a one-cycle match_set pulse.
module axil_timer_core
    import soc_timer_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      en_i,
    input  logic                      auto_reload_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic [31:0]               compare_i,
    input  logic                      count_we_i,
    input  logic [31:0]               count_wdata_i,
    input  logic                      psc_clr_i,
    output logic [31:0]               count_o,
    output logic                      match_set_c_o
);
    logic [PRESCALE_WIDTH-1:0] psc_q, psc_d;
    logic [31:0]               count_q, count_d;
    logic                      tick;

    // A software COUNT write overrides the tick; the compare still uses the pre-write value.
    always_comb begin
        psc_d         = psc_q;
        count_d       = count_q;
        tick          = en_i && (psc_q == prescale_i);
        match_set_c_o = tick && (count_q == compare_i);

        if (!en_i || psc_clr_i || tick) psc_d = '0;
        else                            psc_d = psc_q + PRESCALE_WIDTH'(1);

        if (count_we_i)                           count_d = count_wdata_i;
        else if (match_set_c_o && auto_reload_i)  count_d = '0;
        else if (tick)                            count_d = count_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            psc_q   <= '0;
            count_q <= '0;
        end else begin
            psc_q   <= psc_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/axil_timer.sv
// AXI4-Lite timer: channel handshakes and register file around axil_timer_core.
module axil_timer
    import soc_timer_pkg::*;
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          reset_i,
    axil_timer_if.slave   s_axi,
    output logic          irq_o
);
    if (DATA_WIDTH != 32) begin : g_dw_check
        $error("axil_timer: DATA_WIDTH must be 32");
    end

    logic                      wr_ready_q, wr_ready_d;
    logic                      bvalid_q, bvalid_d;
    resp_t                     bresp_q, bresp_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q, rvalid_d;
    resp_t                     rresp_q, rresp_d;
    logic [31:0]               rdata_q, rdata_d;
    ctrl_t                     ctrl_q, ctrl_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [31:0]               compare_q, compare_d;
    logic                      match_q, match_d;
    logic                      irq_q, irq_d;

    logic        wr_fire, rd_fire;
    logic [4:0]  wr_off, rd_off;
    logic        count_we, psc_clr, match_set;
    logic [31:0] count, count_wdata;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{s_axi.awaddr[ADDR_WIDTH-1:5], s_axi.awaddr[1:0],
                                s_axi.araddr[ADDR_WIDTH-1:5], s_axi.araddr[1:0]};

    // Ready is a registered one-cycle pulse; the access completes on the edge that ends it.
    always_comb begin
        wr_ready_d  = s_axi.awvalid && s_axi.wvalid && !bvalid_q && !wr_ready_q;
        arready_d   = s_axi.arvalid && !rvalid_q && !arready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        ctrl_d      = ctrl_q;
        prescale_d  = prescale_q;
        compare_d   = compare_q;
        match_d     = match_q;
        count_we    = 1'b0;
        psc_clr     = 1'b0;
        wr_off      = {s_axi.awaddr[4:2], 2'b00};
        rd_off      = {s_axi.araddr[4:2], 2'b00};
        wr_fire     = wr_ready_q && s_axi.awvalid && s_axi.wvalid;
        rd_fire     = arready_q && s_axi.arvalid;
        count_wdata = apply_strb(count, s_axi.wdata, s_axi.wstrb);

        if (bvalid_q && s_axi.bready) bvalid_d = 1'b0;
        if (wr_fire) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            case (wr_off)
                TIMER_CTRL_OFF: begin
                    if (s_axi.wstrb[0]) begin
                        ctrl_d.en          = s_axi.wdata[CTRL_EN_BIT];
                        ctrl_d.auto_reload = s_axi.wdata[CTRL_AUTO_RELOAD_BIT];
                        ctrl_d.irq_en      = s_axi.wdata[CTRL_IRQ_EN_BIT];
                    end
                end
                TIMER_PRESCALE_OFF: begin
                    prescale_d = PRESCALE_WIDTH'(apply_strb(32'(prescale_q), s_axi.wdata, s_axi.wstrb));
                    psc_clr    = 1'b1;
                end
                TIMER_COUNT_OFF: begin
                    count_we = 1'b1;
                    psc_clr  = 1'b1;
                end
                TIMER_COMPARE_OFF: compare_d = apply_strb(compare_q, s_axi.wdata, s_axi.wstrb);
                TIMER_STATUS_OFF:  if (s_axi.wstrb[0] && s_axi.wdata[0]) match_d = 1'b0;
                default:           bresp_d = RESP_SLVERR;
            endcase
        end
        // A hardware match outranks a same-cycle software clear.
        if (match_set) match_d = 1'b1;
        irq_d = match_d && ctrl_d.irq_en;

        if (rvalid_q && s_axi.rready) rvalid_d = 1'b0;
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            case (rd_off)
                TIMER_CTRL_OFF:     rdata_d = {29'b0, ctrl_q};
                TIMER_PRESCALE_OFF: rdata_d = 32'(prescale_q);
                TIMER_COUNT_OFF:    rdata_d = count;
                TIMER_COMPARE_OFF:  rdata_d = compare_q;
                TIMER_STATUS_OFF:   rdata_d = {31'b0, match_q};
                default: begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ready_q <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            ctrl_q     <= '0;
            prescale_q <= '0;
            compare_q  <= '0;
            match_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            wr_ready_q <= wr_ready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            irq_q      <= irq_d;
        end
    end

    axil_timer_core u_core (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .en_i          (ctrl_q.en),
        .auto_reload_i (ctrl_q.auto_reload),
        .prescale_i    (prescale_q),
        .compare_i     (compare_q),
        .count_we_i    (count_we),
        .count_wdata_i (count_wdata),
        .psc_clr_i     (psc_clr),
        .count_o       (count),
        .match_set_c_o (match_set)
    );

    assign s_axi.awready = wr_ready_q;
    assign s_axi.wready  = wr_ready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;
    assign irq_o         = irq_q;
endmodule

// File: tb/tb_axil_timer.sv
// Directed bench for axil_timer: register table, match timing, auto-reload, W1C races, backpressure.
module tb_axil_timer;
    localparam int unsigned LIMIT = 60;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic irq;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   wr_cyc, rd_cyc;
    logic wr_irq;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axil_timer_if #(.ADDR_WIDTH(32)) bus();

    axil_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .s_axi   (bus),
        .irq_o   (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < LIMIT) begin step(); n++; end
        check("wr_ready", 32'({bus.awready, bus.wready}), 32'h3);
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        wr_cyc = cyc;
        wr_irq = irq;
        n = 0;
        while (!bus.bvalid && n < LIMIT) begin step(); n++; end
        check("bvalid", 32'(bus.bvalid), 32'h1);
        resp = bus.bresp;
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        bus.araddr = addr; bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < LIMIT) begin step(); n++; end
        check("rd_ready", 32'(bus.arready), 32'h1);
        step();
        bus.arvalid = 1'b0;
        rd_cyc = cyc;
        n = 0;
        while (!bus.rvalid && n < LIMIT) begin step(); n++; end
        check("rvalid", 32'(bus.rvalid), 32'h1);
        data = bus.rdata;
        resp = bus.rresp;
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
    endtask

    task automatic wr_ok(input logic [31:0] addr, input logic [31:0] data);
        logic [1:0] r;
        axi_write(addr, data, 4'hF, r);
        check("wr_resp", 32'(r), 32'(OKAY));
    endtask

    task automatic rd_expect(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(addr, d, r);
        check(name, d, exp);
        check({name, "_resp"}, 32'(r), 32'(OKAY));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t        vt[15];
        logic [31:0] d;
        logic [1:0]  r;
        int          c0, n, tgt, e;

        vt[0]  = '{1'b1, 32'h14, 32'hFFFF_FFFF, 4'hF, 32'h0,         SLVERR};
        vt[1]  = '{1'b0, 32'h14, 32'h0,         4'h0, 32'h0,         SLVERR};
        vt[2]  = '{1'b0, 32'h1C, 32'h0,         4'h0, 32'h0,         SLVERR};
        vt[3]  = '{1'b0, 32'h00, 32'h0,         4'h0, 32'h0,         OKAY};
        vt[4]  = '{1'b0, 32'h08, 32'h0,         4'h0, 32'h0,         OKAY};
        vt[5]  = '{1'b1, 32'h04, 32'hFFFF_1234, 4'h1, 32'h0,         OKAY};
        vt[6]  = '{1'b0, 32'h04, 32'h0,         4'h0, 32'h34,        OKAY};
        vt[7]  = '{1'b1, 32'h0C, 32'hAABB_CCDD, 4'hF, 32'h0,         OKAY};
        vt[8]  = '{1'b1, 32'h0C, 32'h1122_3344, 4'h4, 32'h0,         OKAY};
        vt[9]  = '{1'b0, 32'h0C, 32'h0,         4'h0, 32'hAA22_CCDD, OKAY};
        vt[10] = '{1'b1, 32'h00, 32'hFFFF_FFFE, 4'hF, 32'h0,         OKAY};
        vt[11] = '{1'b0, 32'h00, 32'h0,         4'h0, 32'h6,         OKAY};
        vt[12] = '{1'b0, 32'h10, 32'h0,         4'h0, 32'h0,         OKAY};
        vt[13] = '{1'b1, 32'h18, 32'h5,         4'hF, 32'h0,         SLVERR};
        vt[14] = '{1'b0, 32'h08, 32'h0,         4'h0, 32'h0,         OKAY};

        // Reset state and all five offsets reading zero
        do_reset();
        check("rst_outs", 32'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, irq}), 32'h0);
        check("rst_resp_data", {bus.rdata[29:0], bus.bresp}, 32'h0);
        for (int i = 0; i < 5; i++) rd_expect($sformatf("rst_rd%0d", i), 32'(i * 4), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);

        // Match latency: PRESCALE=3, COMPARE=5, IRQ_EN|EN
        wr_ok(32'h04, 32'd3);
        wr_ok(32'h0C, 32'd5);
        wr_ok(32'h08, 32'd0);
        wr_ok(32'h00, 32'h5);
        c0 = wr_cyc;
        n = 0;
        while (!irq && n < 100) begin step(); n++; end
        check("t2_irq_rise", 32'(irq), 32'h1);
        check("t2_latency", 32'(cyc - c0), 32'd24);
        rd_expect("t2_count_a", 32'h08, 32'd6);
        rd_expect("t2_count_b", 32'h08, 32'd7);
        rd_expect("t2_status", 32'h10, 32'd1);

        // Auto-reload: COUNT = (ticks mod 6), MATCH from the first wrap onward
        do_reset();
        wr_ok(32'h04, 32'd3);
        wr_ok(32'h0C, 32'd5);
        wr_ok(32'h08, 32'd0);
        wr_ok(32'h00, 32'h7);
        c0 = wr_cyc;
        for (int i = 0; i < 16; i++) begin
            axi_read(32'h08, d, r);
            e = rd_cyc - 1 - c0;
            check($sformatf("t3_count%0d", i), d, 32'((e / 4) % 6));
            check($sformatf("t3_irq%0d", i), 32'(irq), 32'((cyc - c0) >= 24));
        end

        // W1C away from a match clears; W1C on the match edge loses to the set
        if (((cyc + 2 - c0) % 24) == 0) step();
        axi_write(32'h10, 32'h1, 4'hF, r);
        check("t4_clr_irq", 32'(wr_irq), 32'h0);
        rd_expect("t4_clr_status", 32'h10, 32'd0);
        tgt = c0 + 24 * ((cyc + 3 - c0 + 23) / 24);
        n = 0;
        while (cyc < tgt - 2 && n < LIMIT) begin step(); n++; end
        axi_write(32'h10, 32'h1, 4'hF, r);
        check("t4_race_edge", 32'(wr_cyc), 32'(tgt));
        check("t4_race_irq", 32'(wr_irq), 32'h1);
        rd_expect("t4_race_status", 32'h10, 32'd1);

        // Unmapped offsets and byte strobes from the vector table
        do_reset();
        for (int i = 0; i < 15; i++) begin
            if (vt[i].wr) begin
                axi_write(vt[i].addr, vt[i].data, vt[i].strb, r);
            end else begin
                axi_read(vt[i].addr, d, r);
                check($sformatf("vec%0d_data", i), d, vt[i].exp_data);
            end
            check($sformatf("vec%0d_resp", i), 32'(r), 32'(vt[i].exp_resp));
        end

        // COUNT wrap past 0xFFFFFFFF with no MATCH
        wr_ok(32'h04, 32'd0);
        wr_ok(32'h0C, 32'h1000);
        wr_ok(32'h08, 32'hFFFF_FFFF);
        wr_ok(32'h00, 32'h5);
        c0 = wr_cyc;
        axi_read(32'h08, d, r);
        check("t5_wrap_count", d, 32'hFFFF_FFFF + 32'(rd_cyc - 1 - c0));
        rd_expect("t5_wrap_status", 32'h10, 32'd0);
        check("t5_wrap_irq", 32'(irq), 32'h0);

        // Write response backpressure with a second request pending
        do_reset();
        bus.awaddr = 32'h0C; bus.wdata = 32'h55; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < LIMIT) begin step(); n++; end
        step();
        bus.awaddr = 32'h14; bus.wdata = 32'h99;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_wr_hold%0d", i), 32'({bus.bvalid, bus.bresp, bus.awready, bus.wready}), 32'b10000);
            step();
        end
        bus.bready = 1'b1; step(); bus.bready = 1'b0;
        n = 0;
        while (!bus.awready && n < LIMIT) begin step(); n++; end
        check("bp_wr_reaccept", 32'(n), 32'd1);
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("bp_wr_second", 32'({bus.bvalid, bus.bresp}), {29'b0, 1'b1, SLVERR});
        bus.bready = 1'b1; step(); bus.bready = 1'b0;

        // Read response backpressure with a second request pending
        bus.araddr = 32'h0C; bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < LIMIT) begin step(); n++; end
        step();
        bus.araddr = 32'h14;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_rd_hold%0d", i), 32'({bus.rvalid, bus.rresp, bus.arready}), 32'b1000);
            check($sformatf("bp_rd_data%0d", i), bus.rdata, 32'h55);
            step();
        end
        bus.rready = 1'b1; step(); bus.rready = 1'b0;
        n = 0;
        while (!bus.arready && n < LIMIT) begin step(); n++; end
        check("bp_rd_reaccept", 32'(n), 32'd1);
        step();
        bus.arvalid = 1'b0;
        check("bp_rd_second", 32'({bus.rvalid, bus.rresp}), {29'b0, 1'b1, SLVERR});
        check("bp_rd_second_data", bus.rdata, 32'h0);
        bus.rready = 1'b1; step(); bus.rready = 1'b0;
        rd_expect("bp_compare_kept", 32'h0C, 32'h55);

        // Reset while a read response is pending
        bus.araddr = 32'h0C; bus.arvalid = 1'b1;
        n = 0;
        while (!bus.rvalid && n < LIMIT) begin step(); n++; end
        bus.arvalid = 1'b0;
        check("mid_rst_pre", 32'(bus.rvalid), 32'h1);
        rst = 1'b1;
        step();
        check("mid_rst_drop", 32'({bus.rvalid, bus.bvalid}), 32'h0);
        check("mid_rst_rdata", bus.rdata, 32'h0);
        rst = 1'b0;
        step();
        rd_expect("mid_rst_compare", 32'h0C, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
